// File: rtl/soc_display_scan_pkg.sv
// Shared definitions for the SoC debug display scanner: page codes,
// blanking constants and the active-low hex segment table.
package soc_display_scan_pkg;

    typedef enum logic [1:0] {
        PAGE_REG12 = 2'd0,
        PAGE_REG34 = 2'd1,
        PAGE_PC    = 2'd2,
        PAGE_ALU   = 2'd3
    } page_e;

    localparam logic [3:0] AN_BLANK  = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic       DP_BLANK  = 1'b1;

    // Entry n is the {g..a} pattern for hex digit n; a 0 bit lights the segment.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [3:0] nibble_of(input logic [15:0] snap,
                                             input logic [1:0]  idx);
        return snap[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/soc_display_scan_hex7seg.sv
// Combinational 4-bit value to active-low 7-segment pattern decoder.
module hex7seg
    import soc_display_scan_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/soc_display_scan.sv
// Four-digit multiplexed 7-segment scanner showing a frame-stable snapshot of
// SoC state, with a sticky exception flag blinked on the decimal point.
module soc_display_scan
    import soc_display_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int BLINK_FRAMES = 32,
    parameter int REG_WIDTH    = 8,
    parameter int PC_WIDTH     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           Sel,
    input  logic                 Hold,
    input  logic                 ExcClear,
    input  logic [REG_WIDTH-1:0] Register1,
    input  logic [REG_WIDTH-1:0] Register2,
    input  logic [REG_WIDTH-1:0] Register3,
    input  logic [REG_WIDTH-1:0] Register4,
    input  logic [REG_WIDTH-1:0] WriteBack,
    input  logic [REG_WIDTH-1:0] ALUResult,
    input  logic [PC_WIDTH-1:0]  PCout,
    input  logic [2:0]           ExceptionCause,
    output logic [3:0]           An,
    output logic [6:0]           Seg,
    output logic                 Dp,
    output logic                 ExcLatched
);

    localparam int RW8 = (REG_WIDTH < 8) ? REG_WIDTH : 8;
    localparam int PW6 = (PC_WIDTH < 6) ? PC_WIDTH : 6;
    localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [SCAN_DIV-1:0] r_presc;
    logic [1:0]          r_idx;
    logic [15:0]         r_snap;
    logic [BW-1:0]       r_blink_cnt;
    logic                r_blink_phase;
    logic                r_exc;
    logic [3:0]          r_an;
    logic [6:0]          r_seg;
    logic                r_dp;

    logic                w_tick;
    logic                w_frame_start;
    logic [1:0]          w_idx_next;
    logic [15:0]         w_page_val;
    logic [15:0]         w_snap_next;
    logic                w_exc_next;
    logic                w_phase_next;
    logic [3:0]          w_nibble;
    logic [6:0]          w_seg;
    logic [7:0]          w_r1, w_r2, w_r3, w_r4, w_wb, w_alu;
    logic [5:0]          w_pc;

    assign w_tick        = &r_presc;
    assign w_idx_next    = r_idx + 2'd1;
    assign w_frame_start = w_tick && (r_idx == 2'd3);

    // Fit the observed values into the fixed 16-bit page layout.
    always_comb begin
        w_r1  = '0;
        w_r2  = '0;
        w_r3  = '0;
        w_r4  = '0;
        w_wb  = '0;
        w_alu = '0;
        w_pc  = '0;
        w_r1[RW8-1:0]  = Register1[RW8-1:0];
        w_r2[RW8-1:0]  = Register2[RW8-1:0];
        w_r3[RW8-1:0]  = Register3[RW8-1:0];
        w_r4[RW8-1:0]  = Register4[RW8-1:0];
        w_wb[RW8-1:0]  = WriteBack[RW8-1:0];
        w_alu[RW8-1:0] = ALUResult[RW8-1:0];
        w_pc[PW6-1:0]  = PCout[PW6-1:0];
    end

    always_comb begin
        w_page_val = '0;
        case (page_e'(Sel))
            PAGE_REG12: w_page_val = {w_r1, w_r2};
            PAGE_REG34: w_page_val = {w_r3, w_r4};
            PAGE_PC:    w_page_val = {2'b00, w_pc, 5'b00000, ExceptionCause};
            PAGE_ALU:   w_page_val = {w_wb, w_alu};
            default:    w_page_val = '0;
        endcase
    end

    // The first digit of a frame must already show the freshly loaded snapshot,
    // so the display path decodes the next-state values, not the registers.
    assign w_snap_next  = (w_frame_start && !Hold) ? w_page_val : r_snap;
    assign w_exc_next   = (ExceptionCause != 3'd0) ? 1'b1 :
                          (ExcClear ? 1'b0 : r_exc);
    assign w_phase_next = (w_frame_start && (r_blink_cnt == BLINK_LAST)) ?
                          ~r_blink_phase : r_blink_phase;
    assign w_nibble     = nibble_of(w_snap_next, w_idx_next);

    hex7seg u_hex7seg (
        .i_hex (w_nibble),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_idx   <= 2'd3;
        end else begin
            r_presc <= r_presc + SCAN_DIV'(1);
            if (w_tick) begin
                r_idx <= w_idx_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap        <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_snap        <= w_snap_next;
            r_blink_phase <= w_phase_next;
            if (w_frame_start) begin
                r_blink_cnt <= (r_blink_cnt == BLINK_LAST) ? '0 :
                               r_blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exc <= 1'b0;
        end else begin
            r_exc <= w_exc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an  <= AN_BLANK;
            r_seg <= SEG_BLANK;
            r_dp  <= DP_BLANK;
        end else if (w_tick) begin
            r_an  <= ~(4'b0001 << w_idx_next);
            r_seg <= w_seg;
            r_dp  <= ~(w_exc_next & w_phase_next);
        end
    end

    assign An         = r_an;
    assign Seg        = r_seg;
    assign Dp         = r_dp;
    assign ExcLatched = r_exc;

endmodule

// File: tb/tb_soc_display_scan.sv
// Bench for soc_display_scan: table-driven page vectors, hand-written
// hold/exception/reset sequences and randomized traffic against a frame model.
module tb_soc_display_scan;

  localparam int SD = 2;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] Sel;
  logic       Hold, ExcClear;
  logic [7:0] Register1, Register2, Register3, Register4, WriteBack, ALUResult;
  logic [5:0] PCout;
  logic [2:0] ExceptionCause;
  logic [3:0] An;
  logic [6:0] Seg;
  logic       Dp, ExcLatched;

  soc_display_scan #(
    .SCAN_DIV(SD), .BLINK_FRAMES(BF), .REG_WIDTH(8), .PC_WIDTH(6)
  ) dut (
    .clk(clk), .rst(rst), .Sel(Sel), .Hold(Hold), .ExcClear(ExcClear),
    .Register1(Register1), .Register2(Register2), .Register3(Register3),
    .Register4(Register4), .WriteBack(WriteBack), .ALUResult(ALUResult),
    .PCout(PCout), .ExceptionCause(ExceptionCause),
    .An(An), .Seg(Seg), .Dp(Dp), .ExcLatched(ExcLatched)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Standard hex glyphs, active-low {g..a}.
  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [15:0] page_value(input logic [1:0] s);
    case (s)
      2'd0: return {Register1, Register2};
      2'd1: return {Register3, Register4};
      2'd2: return {2'b00, PCout, 5'b00000, ExceptionCause};
      default: return {WriteBack, ALUResult};
    endcase
  endfunction

  // Reference model: clock edges since reset release determine tick number,
  // digit position and frame count arithmetically.
  int m_k, m_ticks, m_frames, m_idx;
  logic [15:0] m_snap;
  logic        m_exc, m_dp;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_k = 0; m_ticks = 0; m_frames = 0; m_idx = 3; m_snap = '0;
      m_exc = 1'b0; m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
    end else begin
      m_k++;
      if (ExceptionCause != 3'd0) m_exc = 1'b1;
      else if (ExcClear) m_exc = 1'b0;
      if (m_k % (1 << SD) == 0) begin
        m_ticks++;
        m_idx = (m_ticks - 1) % 4;
        if (m_idx == 0) begin
          m_frames++;
          if (!Hold) m_snap = page_value(Sel);
        end
        m_an = 4'hF;
        m_an[m_idx] = 1'b0;
        m_seg = seg_ref(m_snap[m_idx*4 +: 4]);
        m_dp = !(m_exc && (((m_frames / BF) % 2) == 1));
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_an", An, m_an);
      check("model_seg", Seg, m_seg);
      check("model_dp", Dp, m_dp);
      check("model_exc", ExcLatched, m_exc);
    end
  end

  task automatic wait_tick();
    int t0 = m_ticks;
    bit seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (m_ticks != t0) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL tick_timeout: got none expected tick within 16 cycles");
    end
  endtask

  task automatic wait_frame();
    int f0 = m_frames;
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (m_frames != f0) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL frame_timeout: got none expected frame within 40 cycles");
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  r1, r2, r3, r4, wb, alu;
    logic [5:0]  pc;
    logic [2:0]  cause;
    logic [15:0] exp_snap;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] an_e[4];
    logic       d[6];
    an_e = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    vecs[0] = '{2'd0, 8'h3A, 8'hC5, 8'h00, 8'h00, 8'h00, 8'h00, 6'h00, 3'd0, 16'h3AC5};
    vecs[1] = '{2'd1, 8'h00, 8'h00, 8'h12, 8'hEF, 8'h00, 8'h00, 6'h00, 3'd0, 16'h12EF};
    vecs[2] = '{2'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 6'h2F, 3'd4, 16'h2F04};
    vecs[3] = '{2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h9B, 8'h60, 6'h00, 3'd0, 16'h9B60};
    vecs[4] = '{2'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 6'h3F, 3'd0, 16'h3F00};

    Sel = 2'd0; Hold = 1'b0; ExcClear = 1'b0;
    Register1 = 8'h3A; Register2 = 8'hC5; Register3 = 8'h00; Register4 = 8'h00;
    WriteBack = 8'h00; ALUResult = 8'h00; PCout = 6'h00; ExceptionCause = 3'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_an", An, 4'b1111);
    check("rst_seg", Seg, 7'h7F);
    check("rst_dp", Dp, 1'b1);
    check("rst_exc", ExcLatched, 1'b0);
    rst = 1'b1;
    cmp_en = 1'b1;

    // First frame after release: 3AC5 shown as 5, C, A, 3
    wait_tick();
    check("first_an", An, 4'b1110);
    check("first_seg", Seg, 7'h12);
    for (int i = 1; i < 4; i++) begin
      wait_tick();
      check("scan_an", An, an_e[i]);
      check("scan_seg", Seg, seg_ref(vecs[0].exp_snap[i*4 +: 4]));
    end

    // Page vectors
    for (int v = 0; v < 5; v++) begin
      Sel = vecs[v].sel; Register1 = vecs[v].r1; Register2 = vecs[v].r2;
      Register3 = vecs[v].r3; Register4 = vecs[v].r4; WriteBack = vecs[v].wb;
      ALUResult = vecs[v].alu; PCout = vecs[v].pc; ExceptionCause = vecs[v].cause;
      wait_frame();
      for (int i = 0; i < 4; i++) begin
        if (i > 0) wait_tick();
        check("vec_an", An, an_e[i]);
        check("vec_seg", Seg, seg_ref(vecs[v].exp_snap[i*4 +: 4]));
      end
    end
    check("exc_after_cause4", ExcLatched, 1'b1);

    // Blink: with the flag latched, Dp alternates every BF frames
    ExceptionCause = 3'd0;
    for (int i = 0; i < 6; i++) begin
      wait_frame();
      d[i] = Dp;
    end
    for (int i = 0; i < 4; i++) check("dp_blink", d[i] ^ d[i+2], 1'b1);

    // Clear, then simultaneous set and clear, then clear again
    ExcClear = 1'b1;
    @(negedge clk);
    check("exc_clear", ExcLatched, 1'b0);
    ExceptionCause = 3'd1;
    @(negedge clk);
    check("exc_set_wins", ExcLatched, 1'b1);
    ExceptionCause = 3'd0;
    @(negedge clk);
    check("exc_clear2", ExcLatched, 1'b0);
    ExcClear = 1'b0;
    wait_tick();
    for (int i = 0; i < 10; i++) begin
      wait_tick();
      check("dp_off_after_clear", Dp, 1'b1);
    end

    // Hold: freeze 3AC5 while Register1 becomes FF
    Sel = 2'd0; Register1 = 8'h3A; Register2 = 8'hC5;
    wait_frame();
    wait_tick();
    Hold = 1'b1; Register1 = 8'hFF;
    for (int f = 0; f < 2; f++) begin
      wait_frame();
      check("hold_d0", Seg, 7'h12);
      wait_tick();
      wait_tick();
      check("hold_d2", Seg, 7'h08);
      wait_tick();
      check("hold_d3", Seg, 7'h30);
    end
    wait_frame();
    wait_tick();
    Hold = 1'b0;
    wait_tick();
    check("unhold_d2_old", Seg, 7'h08);
    wait_tick();
    check("unhold_d3_old", Seg, 7'h30);
    wait_tick();
    check("unhold_d0", An, 4'b1110);
    wait_tick();
    wait_tick();
    check("unhold_d2_new", Seg, 7'h0E);
    wait_tick();
    check("unhold_d3_new", Seg, 7'h0E);

    // Reset during digit 2
    for (int i = 0; i < 8 && m_idx != 2; i++) wait_tick();
    check("pre_rst_an", An, 4'b1011);
    cmp_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_an", An, 4'b1111);
    check("mid_rst_seg", Seg, 7'h7F);
    check("mid_rst_dp", Dp, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;
    wait_tick();
    check("restart_an", An, 4'b1110);
    check("restart_seg", Seg, 7'h12);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      Sel = 2'($urandom_range(0, 3));
      Hold = ($urandom_range(0, 3) == 0);
      ExcClear = ($urandom_range(0, 3) == 0);
      Register1 = 8'($urandom); Register2 = 8'($urandom);
      Register3 = 8'($urandom); Register4 = 8'($urandom);
      WriteBack = 8'($urandom); ALUResult = 8'($urandom);
      PCout = 6'($urandom);
      ExceptionCause = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    end
    @(negedge clk);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/soc_display_scan.md
SOC_DISPLAY_SCAN -- requirements
Module: soc_display_scan

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  SCAN_DIV, 16, prescaler width; one digit tick every 2^SCAN_DIV clocks.
  BLINK_FRAMES, 32, frames per blink half-period.
  REG_WIDTH, 8, width of register and data inputs.
  PC_WIDTH, 6, PC width.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  single system clock.
  rst  in  1  asynchronous, active-low reset.
  Sel  in  2  page: 0 = Register1:Register2, 1 = Register3:Register4, 2 = PC:Cause, 3 = WriteBack:ALUResult.
  Hold  in  1  freeze the displayed snapshot.
  ExcClear  in  1  clear the sticky exception flag.
  Register1..Register4  in  REG_WIDTH each  architectural registers from the SoC.
  WriteBack, ALUResult  in  REG_WIDTH each  pipeline observation values.
  PCout  in  PC_WIDTH  current PC.
  ExceptionCause  in  3  exception cause; 0 = none.
  An  out  4  digit anodes, active-low, one-hot-low.
  Seg  out  7  segments {g..a}, active-low.
  Dp  out  1  decimal point, active-low.
  ExcLatched  out  1  sticky exception flag.

Function
REQ-003 The prescaler SHALL count 0..2^SCAN_DIV-1 and wrap; the tick SHALL be asserted for one clock at the terminal count.
REQ-004 On each tick, the digit index (2 bit) SHALL advance 0→1→2→3→0.
REQ-005 A frame start SHALL be a tick on which the index wraps 3→0.
REQ-006 At frame start with Hold=0, the 16-bit snapshot SHALL load the Sel page:
  - Pages 0, 1, 3: {first operand, second operand}.
  - Page 2: {2'b00, PCout, 5'b0, ExceptionCause}.
REQ-007 At frame start with Hold=1, the snapshot SHALL be retained.
REQ-008 Sel and Hold changes mid-frame SHALL have no effect before the next frame start.
REQ-009 Digit i SHALL show snapshot nibble i; digit 3 SHALL be the most significant nibble.
REQ-010 An, Seg and Dp SHALL be registered and SHALL update on the clock edge of the tick, with all three changing in the same cycle.
REQ-011 The visible digit SHALL be An = ~(4'b0001 << index).
REQ-012 Seg SHALL be the standard hex encoding of 0-F, active-low; for example 0 = 7'b1000000, 8 = 7'b0000000, F = 7'b0001110.
REQ-013 ExcLatched SHALL set on any clock with ExceptionCause != 0.
REQ-014 ExcLatched SHALL clear on ExcClear=1 only when ExceptionCause = 0; set wins over clear on simultaneous events.
REQ-015 The blink counter SHALL count frames and SHALL toggle blink_phase every BLINK_FRAMES frames.
REQ-016 Dp SHALL be 0 (lit) only when ExcLatched=1 and blink_phase=1; otherwise Dp SHALL be 1.

Reset
REQ-017 While rst=0, the block SHALL hold these values asynchronously:
  - prescaler=0, index=3, snapshot=0, blink counter=0, blink_phase=0.
  - An=4'b1111, Seg=7'b1111111, Dp=1, ExcLatched=0.
REQ-018 After rst release, the first tick SHALL be a frame start: it loads the snapshot, then drives An=4'b1110 and digit 0.
REQ-019 Reset asserted mid-frame SHALL blank the outputs immediately, with no partial digit retained.

Structure
REQ-020 The shared package SHALL hold:
  - page codes PAGE_REG12, PAGE_REG34, PAGE_PC, PAGE_ALU;
  - the active-low blank constants;
  - the 16-entry segment table.
REQ-021 A single sub-module, hex7seg, SHALL implement the combinational 4-bit to 7-segment decode; all state SHALL reside in soc_display_scan.

Verification (SCAN_DIV=2, BLINK_FRAMES=2)
REQ-022 Reset release, Sel=0, Register1=8'h3A, Register2=8'hC5:
  - First tick: An=1110, Seg=hex 5.
  - Subsequent ticks: C, A, 3, in order with An 1101, 1011, 0111.
REQ-023 Sel=2, PCout=6'h2F, ExceptionCause=3'd4:
  - Snapshot = 16'h2F04.
  - ExcLatched=1 from the next clock.
  - Dp toggles lit/unlit every 2 frames.
REQ-024 Hold=1 asserted mid-frame, then Register1 changed to 8'hFF:
  - Digits keep the old value for every later frame.
  - After Hold=0, the new value appears at the next frame start, not before.
REQ-025 ExcClear=1 in the same cycle as ExceptionCause=3'd1: ExcLatched stays 1.
REQ-026 ExcClear=1 with ExceptionCause=0: ExcLatched=0 the next clock, and Dp=1 thereafter.
REQ-027 rst pulsed low during digit 2: An=1111 and Seg=1111111 within the same cycle; after release the sequence restarts at digit 0 per REQ-018.
